// File: rtl/uart_tx_arbiter.sv
// Three-requester arbiter in front of a single UART transmitter.
// Round-robin grant, optional locked bursts capped at MAX_BURST bytes.
module uart_tx_arbiter #(
    parameter int unsigned MAX_BURST = 116
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] lock,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic       busy,
    output logic       new_data_tx,
    output logic [7:0] data_tx,
    output logic [2:0] ack,
    output logic [1:0] owner,
    output logic       owner_valid,
    output logic [7:0] burst_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t     r_state;
    logic [1:0] r_last;
    logic       r_newDataTx;
    logic [7:0] r_dataTx;
    logic [2:0] r_ack;
    logic [1:0] r_owner;
    logic       r_ownerValid;
    logic [7:0] r_burstCnt;

    state_t     w_nextState;
    logic [1:0] w_nextLast;
    logic       w_nextNewDataTx;
    logic [7:0] w_nextDataTx;
    logic [2:0] w_nextAck;
    logic [1:0] w_nextOwner;
    logic       w_nextOwnerValid;
    logic [7:0] w_nextBurstCnt;

    logic [1:0] w_rrPick;
    logic       w_ownerReq;
    logic       w_ownerLock;
    logic [7:0] w_ownerData;
    logic       w_burstFull;

    assign w_burstFull = (r_burstCnt == 8'(MAX_BURST));

    // Search order starts one past the previous holder so every requester gets a turn.
    always_comb begin
        w_rrPick = 2'd0;
        case (r_last)
            2'd0:    w_rrPick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    w_rrPick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: w_rrPick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        w_ownerReq  = req[2];
        w_ownerLock = lock[2];
        w_ownerData = data2;
        case (r_owner)
            2'd0: begin
                w_ownerReq  = req[0];
                w_ownerLock = lock[0];
                w_ownerData = data0;
            end
            2'd1: begin
                w_ownerReq  = req[1];
                w_ownerLock = lock[1];
                w_ownerData = data1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_nextState      = r_state;
        w_nextLast       = r_last;
        w_nextNewDataTx  = 1'b0;
        w_nextDataTx     = r_dataTx;
        w_nextAck        = 3'b000;
        w_nextOwner      = r_owner;
        w_nextOwnerValid = r_ownerValid;
        w_nextBurstCnt   = r_burstCnt;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_nextOwner      = w_rrPick;
                    w_nextOwnerValid = 1'b1;
                    w_nextBurstCnt   = 8'd0;
                    w_nextState      = SEND;
                end
            end
            SEND: begin
                if (!w_ownerReq) begin
                    w_nextLast       = r_owner;
                    w_nextOwnerValid = 1'b0;
                    w_nextState      = IDLE;
                end else if (!busy) begin
                    w_nextNewDataTx = 1'b1;
                    w_nextDataTx    = w_ownerData;
                    w_nextAck       = 3'b001 << r_owner;
                    w_nextBurstCnt  = r_burstCnt + 8'd1;
                    w_nextState     = GAP;
                end
            end
            GAP: begin
                // The burst cap wins over lock so one requester cannot starve the others.
                if (w_burstFull || !w_ownerLock) begin
                    w_nextLast       = r_owner;
                    w_nextOwnerValid = 1'b0;
                    w_nextState      = IDLE;
                end else if (w_ownerReq) begin
                    w_nextState = SEND;
                end else begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (!w_ownerLock) begin
                    w_nextLast       = r_owner;
                    w_nextOwnerValid = 1'b0;
                    w_nextState      = IDLE;
                end else if (w_ownerReq) begin
                    w_nextState = SEND;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last       <= 2'd2;
            r_newDataTx  <= 1'b0;
            r_dataTx     <= 8'h00;
            r_ack        <= 3'b000;
            r_owner      <= 2'd0;
            r_ownerValid <= 1'b0;
            r_burstCnt   <= 8'd0;
        end else begin
            r_state      <= w_nextState;
            r_last       <= w_nextLast;
            r_newDataTx  <= w_nextNewDataTx;
            r_dataTx     <= w_nextDataTx;
            r_ack        <= w_nextAck;
            r_owner      <= w_nextOwner;
            r_ownerValid <= w_nextOwnerValid;
            r_burstCnt   <= w_nextBurstCnt;
        end
    end

    assign new_data_tx = r_newDataTx;
    assign data_tx     = r_dataTx;
    assign ack         = r_ack;
    assign owner       = r_owner;
    assign owner_valid = r_ownerValid;
    assign burst_cnt   = r_burstCnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed scenarios push expected bytes,
// per-DUT monitors pop and compare on every new_data_tx pulse.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] lock = 3'b000;
    logic [2:0] reqB = 3'b000;
    logic [2:0] lockB = 3'b000;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic [7:0] data2 = 8'h00;
    logic       busy = 1'b0;
    logic       busyAtEdge = 1'b0;

    logic       newDataTx, newDataTxB;
    logic [7:0] dataTx, dataTxB;
    logic [2:0] ack, ackB;
    logic [1:0] owner, ownerB;
    logic       ownerValid, ownerValidB;
    logic [7:0] burstCnt, burstCntB;

    int vectorCount = 0;
    int missCount = 0;
    logic [9:0] expA[$];
    logic [9:0] expB[$];

    uart_tx_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .data0(data0), .data1(data1), .data2(data2), .busy(busy),
        .new_data_tx(newDataTx), .data_tx(dataTx), .ack(ack),
        .owner(owner), .owner_valid(ownerValid), .burst_cnt(burstCnt)
    );

    uart_tx_arbiter #(.MAX_BURST(3)) dutB (
        .clk(clk), .rst(rst), .req(reqB), .lock(lockB),
        .data0(data0), .data1(data1), .data2(data2), .busy(busy),
        .new_data_tx(newDataTxB), .data_tx(dataTxB), .ack(ackB),
        .owner(ownerB), .owner_valid(ownerValidB), .burst_cnt(burstCntB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) busyAtEdge <= busy;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportFail(input string name, input logic [31:0] actual);
        vectorCount++;
        missCount++;
        $display("[TB] FAIL %s: got %0h, expected nothing at %0t", name, actual, $time);
    endtask

    task automatic applyStimulus(input logic [2:0] reqV, input logic [2:0] lockV, input logic busyV);
        req  = reqV;
        lock = lockV;
        busy = busyV;
    endtask

    task automatic pushExp(input bit useB, input logic [1:0] o, input logic [7:0] d);
        if (useB) expB.push_back({o, d});
        else      expA.push_back({o, d});
    endtask

    task automatic waitTx(input bit useB, input int n, input int budget);
        int got = 0;
        for (int cyc = 0; cyc < budget && got < n; cyc++) begin
            @(negedge clk);
            if (useB ? newDataTxB : newDataTx) got++;
        end
        if (got < n) checkOutput("tx_timeout", got, n);
    endtask

    task automatic doReset();
        applyStimulus(3'b000, 3'b000, 1'b0);
        reqB  = 3'b000;
        lockB = 3'b000;
        rst   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_new_data_tx"}, newDataTx, 0);
        checkOutput({tag, "_data_tx"}, dataTx, 8'h00);
        checkOutput({tag, "_ack"}, ack, 3'b000);
        checkOutput({tag, "_owner"}, owner, 2'd0);
        checkOutput({tag, "_owner_valid"}, ownerValid, 0);
        checkOutput({tag, "_burst_cnt"}, burstCnt, 8'd0);
    endtask

    // Monitor for the default-parameter DUT.
    always @(negedge clk) begin
        if (rst) begin
            if (newDataTx) begin
                if (expA.size() == 0) begin
                    reportFail("unexpected_tx", dataTx);
                end else begin
                    logic [9:0] e;
                    e = expA.pop_front();
                    checkOutput("tx_data", dataTx, e[7:0]);
                    checkOutput("tx_ack", ack, 3'b001 << e[9:8]);
                    checkOutput("tx_owner", owner, e[9:8]);
                    checkOutput("tx_while_busy", busyAtEdge, 0);
                end
            end else if (ack != 3'b000) begin
                reportFail("ack_without_tx", ack);
            end
        end
    end

    // Monitor for the MAX_BURST=3 DUT.
    always @(negedge clk) begin
        if (rst) begin
            if (newDataTxB) begin
                if (expB.size() == 0) begin
                    reportFail("unexpected_tx_b", dataTxB);
                end else begin
                    logic [9:0] e;
                    e = expB.pop_front();
                    checkOutput("tx_data_b", dataTxB, e[7:0]);
                    checkOutput("tx_ack_b", ackB, 3'b001 << e[9:8]);
                    checkOutput("tx_owner_b", ownerB, e[9:8]);
                end
            end else if (ackB != 3'b000) begin
                reportFail("ack_without_tx_b", ackB);
            end
        end
    end

    initial begin
        $display("[TB] start");
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        checkOutput("reset_owner_valid_b", ownerValidB, 0);
        rst = 1'b1;

        // Single byte and best-case latency.
        data0 = 8'h5A;
        pushExp(0, 2'd0, 8'h5A);
        applyStimulus(3'b001, 3'b000, 1'b0);
        @(negedge clk);
        checkOutput("grant_no_tx_yet", newDataTx, 0);
        checkOutput("grant_owner_valid", ownerValid, 1);
        checkOutput("grant_owner", owner, 2'd0);
        checkOutput("grant_burst_cnt", burstCnt, 8'd0);
        @(negedge clk);
        checkOutput("latency_two_cycles", newDataTx, 1);
        checkOutput("single_burst_cnt", burstCnt, 8'd1);
        applyStimulus(3'b000, 3'b000, 1'b0);
        @(negedge clk);
        checkOutput("single_pulse_width", newDataTx, 0);
        checkOutput("single_release", ownerValid, 0);
        checkOutput("single_owner_kept", owner, 2'd0);
        checkOutput("single_data_held", dataTx, 8'h5A);

        // Round-robin with all requesters active.
        doReset();
        data0 = 8'hA0; data1 = 8'hB1; data2 = 8'hC2;
        for (int k = 0; k < 6; k++) begin
            logic [1:0] o;
            o = 2'(k % 3);
            pushExp(0, o, (o == 2'd0) ? 8'hA0 : ((o == 2'd1) ? 8'hB1 : 8'hC2));
        end
        applyStimulus(3'b111, 3'b000, 1'b0);
        waitTx(0, 6, 60);
        applyStimulus(3'b000, 3'b000, 1'b0);
        repeat (3) @(negedge clk);

        // Locked burst from requester 1 with transmitter backpressure.
        doReset();
        data1 = 8'h11; data2 = 8'hEE;
        pushExp(0, 2'd1, 8'h11);
        applyStimulus(3'b110, 3'b010, 1'b0);
        for (int b = 0; b < 4; b++) begin
            waitTx(0, 1, 40);
            busy = 1'b1;
            if (b < 3) begin
                data1 = 8'(8'h12 + b);
                pushExp(0, 2'd1, data1);
            end else begin
                pushExp(0, 2'd2, 8'hEE);
                req  = 3'b100;
                lock = 3'b000;
            end
            repeat (10) @(negedge clk);
            if (b < 3) begin
                checkOutput("burst_cnt_locked", burstCnt, b + 1);
                checkOutput("burst_owner", owner, 2'd1);
                checkOutput("burst_owner_valid", ownerValid, 1);
            end else begin
                checkOutput("after_unlock_owner", owner, 2'd2);
                checkOutput("after_unlock_burst_cnt", burstCnt, 8'd0);
            end
            busy = 1'b0;
        end
        waitTx(0, 1, 20);
        applyStimulus(3'b000, 3'b000, 1'b0);
        repeat (3) @(negedge clk);

        // Withdrawal during backpressure, then HOLD.
        doReset();
        data2 = 8'h60;
        applyStimulus(3'b100, 3'b000, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("wait_owner_valid", ownerValid, 1);
        checkOutput("wait_owner", owner, 2'd2);
        applyStimulus(3'b000, 3'b000, 1'b1);
        @(negedge clk);
        checkOutput("withdraw_release", ownerValid, 0);
        checkOutput("withdraw_owner_kept", owner, 2'd2);
        applyStimulus(3'b000, 3'b000, 1'b0);
        @(negedge clk);
        data2 = 8'h77;
        pushExp(0, 2'd2, 8'h77);
        applyStimulus(3'b100, 3'b100, 1'b0);
        waitTx(0, 1, 10);
        applyStimulus(3'b011, 3'b100, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("hold_owner_valid", ownerValid, 1);
        checkOutput("hold_owner", owner, 2'd2);
        checkOutput("hold_burst_cnt", burstCnt, 8'd1);
        data2 = 8'h78;
        pushExp(0, 2'd2, 8'h78);
        applyStimulus(3'b111, 3'b100, 1'b0);
        waitTx(0, 1, 10);
        data0 = 8'h0C;
        pushExp(0, 2'd0, 8'h0C);
        applyStimulus(3'b001, 3'b000, 1'b0);
        @(negedge clk);
        checkOutput("joint_drop_release", ownerValid, 0);
        waitTx(0, 1, 10);
        applyStimulus(3'b000, 3'b000, 1'b0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a locked burst.
        doReset();
        data0 = 8'h31;
        pushExp(0, 2'd0, 8'h31);
        applyStimulus(3'b001, 3'b001, 1'b0);
        waitTx(0, 1, 10);
        #1 rst = 1'b0;
        #1 checkResetValues("async_reset");
        applyStimulus(3'b000, 3'b000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        data0 = 8'h40;
        pushExp(0, 2'd0, 8'h40);
        applyStimulus(3'b111, 3'b000, 1'b0);
        waitTx(0, 1, 10);
        applyStimulus(3'b000, 3'b000, 1'b0);
        repeat (3) @(negedge clk);

        // Forced release at the burst limit on the MAX_BURST=3 instance.
        doReset();
        data0 = 8'hD0; data1 = 8'hD1;
        for (int k = 0; k < 3; k++) pushExp(1, 2'd0, 8'hD0);
        pushExp(1, 2'd1, 8'hD1);
        reqB  = 3'b011;
        lockB = 3'b001;
        waitTx(1, 3, 40);
        checkOutput("limit_burst_cnt", burstCntB, 8'd3);
        waitTx(1, 1, 20);
        reqB  = 3'b000;
        lockB = 3'b000;
        repeat (3) @(negedge clk);

        checkOutput("queue_a_drained", expA.size(), 0);
        checkOutput("queue_b_drained", expB.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
